rgb_swap_seq: RTL and testbench

- Frame-synchronous controller for the RGB channel-swap datapath. Drives its 2-bit mode select.
- Mode changes are accepted from a requester (register/button logic) through a valid/ready handshake and applied only at a frame boundary (VSync active edge), so a frame never tears.
- Optional auto-cycle steps the mode every N frames for demo use.
- Sits in the pixel-clock domain, between control logic and the swap stage.

---
 rtl/rgb_swap_seq.sv | 111 +++++++++++
 tb/tb_rgb_swap_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_swap_seq.sv
// Purpose: frame-synchronous mode controller for the RGB channel-swap stage (request apply + auto-cycle).
// Latency: mode/mode_upd update on the edge sampling the VSync active edge (1 PixelClk after VSync goes active).
// Backpressure: req_ready drops while a captured request waits for the next frame boundary.
module rgb_swap_seq #(
  parameter logic       VS_POL     = 1'b1,
  parameter logic [1:0] RESET_MODE = 2'b00,
  parameter int         CNT_W      = 8
) (
  input  logic             PixelClk,
  input  logic             rst,
  input  logic             vid_pVSync,
  input  logic             req_valid,
  input  logic [1:0]       req_mode,
  output logic             req_ready,
  input  logic             auto_en,
  input  logic [CNT_W-1:0] frames_per_step,
  output logic [1:0]       mode,
  output logic             mode_upd,
  output logic             pending
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [1:0]       pend_reg, pend_reg_n;
  logic [1:0]       mode_n;
  logic             mode_upd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] step_m1;
  logic             vs, vs_d, fb;
  logic             applied;

  // vs is 1 whenever sync is at its active level, whatever the input polarity.
  assign vs = (vid_pVSync == VS_POL);
  // Rising edge of the normalised sync; a sync held active yields a single strobe.
  assign fb = vs & ~vs_d;
  // A step length of 0 behaves like 1, so the compare threshold floors at 0.
  assign step_m1 = (frames_per_step == '0) ? '0 : (frames_per_step - CNT_ONE);

  // State register; vs_d resets to inactive so a sync already active at release counts as an edge.
  always_ff @(posedge PixelClk) begin
    if (rst) begin
      state    <= IDLE;
      pend_reg <= 2'b00;
      mode     <= RESET_MODE;
      mode_upd <= 1'b0;
      cnt      <= '0;
      vs_d     <= 1'b0;
    end else begin
      state    <= state_n;
      pend_reg <= pend_reg_n;
      mode     <= mode_n;
      mode_upd <= mode_upd_n;
      cnt      <= cnt_n;
      vs_d     <= vs;
    end
  end

  // Next-state: request capture/apply, then auto-step only at boundaries where no request applied.
  always_comb begin
    state_n    = state;
    pend_reg_n = pend_reg;
    mode_n     = mode;
    mode_upd_n = 1'b0;
    cnt_n      = cnt;
    req_ready  = 1'b0;
    pending    = 1'b0;
    applied    = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        // A request taken on a boundary cycle waits for the following boundary.
        if (req_valid) begin
          pend_reg_n = req_mode;
          state_n    = PEND;
        end
      end
      PEND: begin
        pending = 1'b1;
        if (fb) begin
          mode_n     = pend_reg;
          mode_upd_n = 1'b1;
          cnt_n      = '0;
          state_n    = IDLE;
          applied    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (fb && !applied) begin
      if (!auto_en) begin
        cnt_n = '0;
      end else if (cnt >= step_m1) begin
        mode_n     = mode + 2'd1;
        mode_upd_n = 1'b1;
        cnt_n      = '0;
      end else if (cnt != CNT_MAX) begin
        cnt_n = cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rgb_swap_seq.sv
// Purpose: self-checking bench for rgb_swap_seq, one active-high and one active-low sync build side by side.
// Latency: outputs compared 1 ns after every rising PixelClk against a frame-level reference model.
// Backpressure: req_ready is compared every cycle against the model's pending state.
module tb_rgb_swap_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       auto_en;
  logic [7:0] fps;
  logic       vsync_n;

  logic       rdy1, upd1, pend1;
  logic [1:0] mode1;
  logic       rdy0, upd0, pend0;
  logic [1:0] mode0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  assign vsync_n = ~vsync;

  rgb_swap_seq #(.VS_POL(1'b1), .RESET_MODE(2'b00), .CNT_W(8)) dut_hi (
    .PixelClk(clk), .rst(rst), .vid_pVSync(vsync),
    .req_valid(req_valid), .req_mode(req_mode), .req_ready(rdy1),
    .auto_en(auto_en), .frames_per_step(fps),
    .mode(mode1), .mode_upd(upd1), .pending(pend1)
  );

  rgb_swap_seq #(.VS_POL(1'b0), .RESET_MODE(2'b10), .CNT_W(8)) dut_lo (
    .PixelClk(clk), .rst(rst), .vid_pVSync(vsync_n),
    .req_valid(req_valid), .req_mode(req_mode), .req_ready(rdy0),
    .auto_en(auto_en), .frames_per_step(fps),
    .mode(mode0), .mode_upd(upd0), .pending(pend0)
  );

  typedef struct {
    int mode;
    bit pend;
    int pmode;
    int frames;
    bit sync_prev;
    bit upd;
  } model_t;

  model_t m1, m0;

  // Frame-level reference: frames counts boundaries seen since the last mode change.
  function automatic model_t step(model_t m, int rmode, bit r, bit sync_on, bit rv, int rm, bit ae, int f);
    model_t n;
    bit     edge_now;
    bit     took;
    int     len;
    n = m;
    if (r) begin
      n.mode = rmode; n.pend = 0; n.pmode = 0; n.frames = 0; n.sync_prev = 0; n.upd = 0;
      return n;
    end
    edge_now = sync_on && !m.sync_prev;
    took = 0;
    n.upd = 0;
    if (m.pend) begin
      if (edge_now) begin
        n.mode = m.pmode; n.upd = 1; n.frames = 0; n.pend = 0; took = 1;
      end
    end else if (rv) begin
      n.pend = 1; n.pmode = rm;
    end
    if (edge_now && !took) begin
      len = (f == 0) ? 1 : f;
      if (!ae) n.frames = 0;
      else if (m.frames + 1 >= len) begin
        n.mode = (m.mode + 1) % 4; n.upd = 1; n.frames = 0;
      end else if (m.frames < 255) n.frames = m.frames + 1;
    end
    n.sync_prev = sync_on;
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int pack_exp(model_t m);
    return m.mode * 8 + (m.upd ? 4 : 0) + (m.pend ? 2 : 0) + (m.pend ? 0 : 1);
  endfunction

  // One clock: advance the model on the inputs now applied, then compare both builds.
  task automatic tick();
    int g;
    m1 = step(m1, 0, rst, vsync, req_valid, int'(req_mode), auto_en, int'(fps));
    m0 = step(m0, 2, rst, vsync, req_valid, int'(req_mode), auto_en, int'(fps));
    @(posedge clk);
    #1;
    g = {27'd0, mode1, upd1, pend1, rdy1};
    check("hi_state", g, pack_exp(m1));
    g = {27'd0, mode0, upd0, pend0, rdy0};
    check("lo_state", g, pack_exp(m0));
  endtask

  task automatic frame(input int len, input int vslen, input int req_at, input logic [1:0] rm, input int rst_at);
    for (int i = 0; i < len; i++) begin
      rst       = (i == rst_at);
      vsync     = (i < vslen);
      req_valid = (i == req_at);
      req_mode  = rm;
      tick();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    int len, vsl, rq, ra;
    rst = 1'b1; vsync = 1'b0; req_valid = 1'b0; req_mode = 2'b00; auto_en = 1'b0; fps = 8'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_mode", int'(mode1), 0);
    check("reset_ready", int'(rdy1), 1);

    for (int k = 0; k < 3; k++) frame(30, 3, -1, 2'b00, -1);
    check("idle_mode", int'(mode1), 0);

    frame(30, 3, 10, 2'b10, -1);
    check("held_pending", int'(pend1), 1);
    check("held_mode", int'(mode1), 0);
    frame(30, 3, -1, 2'b00, -1);
    check("applied_mode", int'(mode1), 2);

    frame(30, 3, 0, 2'b01, -1);
    check("fb_same_cycle_hold", int'(mode1), 2);
    frame(30, 3, -1, 2'b00, -1);
    check("fb_same_cycle_next", int'(mode1), 1);

    frame(30, 3, 10, 2'b11, -1);
    frame(30, 3, -1, 2'b00, -1);
    check("start_mode_11", int'(mode1), 3);
    auto_en = 1'b1; fps = 8'd3;
    for (int k = 1; k <= 9; k++) begin
      frame(30, 3, -1, 2'b00, -1);
      if (k % 3 == 0) check("auto_fps3", int'(mode1), k / 3 - 1);
    end

    fps = 8'd0;
    for (int k = 0; k < 3; k++) begin
      frame(30, 3, -1, 2'b00, -1);
      check("auto_fps0", int'(mode1), (3 + k) % 4);
    end

    fps = 8'd2;
    frame(30, 3, 10, 2'b11, -1);
    check("req_vs_auto_wait", int'(mode1), 1);
    frame(30, 3, -1, 2'b00, -1);
    check("req_wins", int'(mode1), 3);
    frame(30, 3, -1, 2'b00, -1);
    check("restart_hold", int'(mode1), 3);
    frame(30, 3, -1, 2'b00, -1);
    check("restart_step", int'(mode1), 0);

    fps = 8'd0;
    frame(60, 45, -1, 2'b00, -1);
    check("long_vsync_one_step", int'(mode1), 1);

    auto_en = 1'b0;
    frame(40, 3, 10, 2'b01, 20);
    frame(40, 3, -1, 2'b00, -1);
    check("rst_drop_hi", int'(mode1), 0);
    check("rst_drop_lo", int'(mode0), 2);

    for (int k = 0; k < 250; k++) begin
      if (k % 20 == 0) auto_en = 1'($urandom_range(0, 1));
      fps = 8'($urandom_range(0, 4));
      len = int'($urandom_range(12, 40));
      vsl = (($urandom_range(0, 9)) == 0) ? len + 1 : int'($urandom_range(1, 4));
      rq  = (($urandom_range(0, 2)) == 0) ? -1 : int'($urandom_range(0, 11));
      ra  = (($urandom_range(0, 24)) == 0) ? int'($urandom_range(6, 11)) : -1;
      frame(len, vsl, rq, 2'($urandom_range(0, 3)), ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
